alu_op_sequencer: RTL
=====================

Name: alu_op_sequencer

Overview:
Upstream feeder for the 8-bit registered ALU (operands number1/number2, 3-bit sel, 16-bit alu_out, one-clock latency, no reset).
- Accepts operation commands over a valid/ready interface and buffers them in a small FIFO.
- Issues one command at a time to the ALU and captures alu_out at the correct cycle.
- Returns each result, with its tag and an error flag, over a second valid/ready interface.
- Shields the ALU from divide-by-zero and illegal opcodes.

Parameters:
DEPTH, 4, command FIFO entries; power of two, minimum 2.
DIV0_RESULT, 16'hFFFF, result returned for divide by zero.

Ports:
clk  in  1  rising-edge clock, shared with ALU
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  FIFO can accept (= !full)
cmd_a  in  8  operand A
cmd_b  in  8  operand B
cmd_op  in  3  001 add, 010 sub, 011 mul, 100 div
cmd_tag  in  4  opaque ID, returned with result
alu_number1  out  8  to ALU number1 (registered)
alu_number2  out  8  to ALU number2 (registered)
alu_sel  out  3  to ALU sel (registered)
alu_result  in  16  from ALU alu_out
res_valid  out  1  result present
res_ready  in  1  consumer accepts
res_data  out  16  result
res_tag  out  4  tag of the command
res_err  out  1  1 = div-by-zero or illegal op
busy  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset (rst=1 at clk edge):
  - FIFO emptied (pointers and count 0) and FSM to IDLE.
  - alu_number1, alu_number2, alu_sel, res_data, res_tag, res_err all 0; res_valid=0.
  - Reset mid-operation discards the in-flight command and all queued commands.
  - cmd_ready=1 from the first cycle after reset.
- FIFO:
  - Push on cmd_valid && cmd_ready. Pop only in IDLE when non-empty.
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - When full, cmd_ready=0 even if a pop occurs that cycle (no same-cycle refill).
  - Pointers wrap modulo DEPTH. FIFO order is strictly preserved.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
  - IDLE: if FIFO non-empty, pop the head and register the operands into alu_*, then go to ISSUE. Otherwise stay; alu_sel holds 000.
    - Divide-by-zero (op=100, b=0): alu_sel=000 and an internal bypass flag is set.
    - Illegal op (000, 101-111): alu_sel=000, bypass flag set.
  - ISSUE: ALU registers the operands on this edge. Go to WAIT.
  - WAIT: alu_result is valid. Capture into res_data, or capture DIV0_RESULT / 0 when bypassed. Capture res_tag; set res_err to the bypass flag; set res_valid=1. Go to HOLD.
  - HOLD: hold res_* stable while res_valid && !res_ready. On res_ready, clear res_valid at the edge and return to IDLE.
    - The next pop happens in IDLE, so back-to-back issue rate is one command per 4 cycles.
- Latency:
  - Command popped at edge t gives res_valid high in the cycle after edge t+2.
  - From the push of a command into an empty, idle block to res_valid: 4 cycles.
- Arithmetic is the ALU's 16-bit result, unmodified:
  - sub is 16-bit two's complement wrap (3-5 = 16'hFFFE).
  - mul is full 16-bit; div is the integer quotient.
- alu_result is sampled only in WAIT, so the ALU's unreset or stale output is never observed.
- busy = (FSM != IDLE) || (count != 0).

Test Plan:
1. Reset then single add: a=8'd200, b=8'd100, op=001, tag=3 -> res_valid 4 cycles after push; res_data=16'd300, tag=3, err=0.
2. Sub wrap and mul max: (3,5,010) then (255,255,011) -> 16'hFFFE then 16'hFE01, in order, err=0; second result appears 4 cycles after the first is accepted.
3. Divide: (200,7,100) -> 16'h001C, err=0. (9,0,100) -> 16'hFFFF, err=1, and alu_sel stays 000 throughout.
4. Illegal op 110 -> res_data=0, err=1, tag preserved.
5. Backpressure and full: hold res_ready=0 and push 6 commands with DEPTH=4.
   - cmd_ready drops after the 5th accepted command (1 in flight + 4 queued).
   - res_* stay stable while stalled.
   - Release res_ready -> all 5 results drain in order, with correct tags and wrap-around.
6. Reset mid-operation: assert rst while in WAIT with 2 commands queued -> next cycle res_valid=0, busy=0, alu_sel=0. A new command then completes normally.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Command FIFO + issue FSM feeding a one-clock registered 8-bit ALU; returns tagged results
// over valid/ready. Divide-by-zero and illegal opcodes never reach the ALU.
module alu_op_sequencer #(
   parameter int          DEPTH       = 4,
   parameter logic [15:0] DIV0_RESULT = 16'hFFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [7:0]  cmd_a,
   input  logic [7:0]  cmd_b,
   input  logic [2:0]  cmd_op,
   input  logic [3:0]  cmd_tag,
   output logic [7:0]  alu_number1,
   output logic [7:0]  alu_number2,
   output logic [2:0]  alu_sel,
   input  logic [15:0] alu_result,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [15:0] res_data,
   output logic [3:0]  res_tag,
   output logic        res_err,
   output logic        busy
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic [2:0] op;
      logic [3:0] tag;
   } cmd_t;

   cmd_t fifo_mem [DEPTH];
   cmd_t head;

   state_t         state_q, state_d;
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]  count_q, count_d;
   logic [7:0]     n1_q, n1_d, n2_q, n2_d;
   logic [2:0]     sel_q, sel_d;
   logic           byp_q, byp_d, div0_q, div0_d;
   logic [3:0]     tag_q, tag_d;
   logic           res_valid_q, res_valid_d;
   logic [15:0]    res_data_q, res_data_d;
   logic [3:0]     res_tag_q, res_tag_d;
   logic           res_err_q, res_err_d;

   logic full, push, pop, head_legal, head_div0;

   assign full      = (count_q == CW'(DEPTH));
   assign cmd_ready = !full;
   assign push      = cmd_valid && cmd_ready;
   assign pop       = (state_q == IDLE) && (count_q != '0);
   assign head      = fifo_mem[rd_ptr_q];

   assign head_legal = (head.op >= 3'd1) && (head.op <= 3'd4);
   assign head_div0  = (head.op == 3'd4) && (head.b == 8'd0);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (!push && pop) count_d = count_q - CW'(1);
   end

   always_comb begin
      state_d     = state_q;
      n1_d        = n1_q;
      n2_d        = n2_q;
      sel_d       = sel_q;
      byp_d       = byp_q;
      div0_d      = div0_q;
      tag_d       = tag_q;
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      res_tag_d   = res_tag_q;
      res_err_d   = res_err_q;
      case (state_q)
         IDLE: begin
            sel_d = 3'b000;
            if (pop) begin
               n1_d    = head.a;
               n2_d    = head.b;
               byp_d   = !head_legal || head_div0;
               div0_d  = head_div0;
               tag_d   = head.tag;
               sel_d   = (!head_legal || head_div0) ? 3'b000 : head.op;
               state_d = ISSUE;
            end
         end
         ISSUE: state_d = WAIT;
         WAIT: begin
            // alu_result is only trusted here, one edge after the ALU latched its operands.
            if (byp_q) res_data_d = div0_q ? DIV0_RESULT : 16'h0000;
            else       res_data_d = alu_result;
            res_tag_d   = tag_q;
            res_err_d   = byp_q;
            res_valid_d = 1'b1;
            state_d     = HOLD;
         end
         HOLD: begin
            if (res_ready) begin
               res_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_q] <= '{a: cmd_a, b: cmd_b, op: cmd_op, tag: cmd_tag};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         n1_q        <= '0;
         n2_q        <= '0;
         sel_q       <= '0;
         byp_q       <= 1'b0;
         div0_q      <= 1'b0;
         tag_q       <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_tag_q   <= '0;
         res_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         n1_q        <= n1_d;
         n2_q        <= n2_d;
         sel_q       <= sel_d;
         byp_q       <= byp_d;
         div0_q      <= div0_d;
         tag_q       <= tag_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_tag_q   <= res_tag_d;
         res_err_q   <= res_err_d;
      end
   end

   assign alu_number1 = n1_q;
   assign alu_number2 = n2_q;
   assign alu_sel     = sel_q;
   assign res_valid   = res_valid_q;
   assign res_data    = res_data_q;
   assign res_tag     = res_tag_q;
   assign res_err     = res_err_q;
   assign busy        = (state_q != IDLE) || (count_q != '0);

endmodule
